// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one 64K byte memory
// between instruction fetch (port 0) and load/store (port 1).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_reqN                  level request from port N, held until ack
//   i_addrN/i_wdataN        byte address / write data of port N
//   i_sizeN                 00 byte, 01/10 halfword, 11 word
//   i_wrN                   1 = write, 0 = read
//   o_ackN                  one-cycle completion pulse for port N
//   o_rdataN                read data for port N, held until its next read
//   o_mem_addr/data/size    latched request driven to the memory
//   o_mem_we                memory write enable, active low
//   i_mem_data              combinational memory read data
//   o_busy                  high whenever the FSM is not idle
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [1:0]  i_size0,
  input  logic [1:0]  i_size1,
  input  logic        i_wr0,
  input  logic        i_wr1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output logic [1:0]  o_mem_size,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        win;

  // On a tie the port that did not win last time is chosen; a lone
  // request wins outright.
  always_comb begin
    if (i_req0 && i_req1) begin
      win = ~last_q;
    end else begin
      win = i_req1;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    wr_d     = wr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          state_d = ACCESS;
          gnt_d   = win;
          last_d  = win;
          addr_d  = win ? i_addr1  : i_addr0;
          wdata_d = win ? i_wdata1 : i_wdata0;
          size_d  = win ? i_size1  : i_size0;
          wr_d    = win ? i_wr1    : i_wr0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!wr_q) begin
          if (gnt_q) begin
            rdata1_d = i_mem_data;
          end else begin
            rdata0_d = i_mem_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Write enable is decoded from state so reset deasserts it immediately.
  assign o_mem_we   = ~((state_q == ACCESS) && wr_q);
  assign o_mem_addr = addr_q;
  assign o_mem_data = wdata_q;
  assign o_mem_size = size_q;
  assign o_ack0     = (state_q == DONE) && !gnt_q;
  assign o_ack1     = (state_q == DONE) &&  gnt_q;
  assign o_rdata0   = rdata0_q;
  assign o_rdata1   = rdata1_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  size [2];
  logic        ack [2];
  logic [31:0] rdata [2];
  logic [31:0] o_mem_addr, o_mem_data, mem_rd;
  logic [1:0]  o_mem_size;
  logic        o_mem_we, o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_low_cnt = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   gq[$];

  logic [7:0]  ref_mem [65536];
  logic [31:0] mem_w [16384];
  bit          written [16384];
  logic [31:0] wcur, wnew;

  mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req[0]), .i_req1(req[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]),
    .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .i_size0(size[0]), .i_size1(size[1]),
    .i_wr0(wr[0]), .i_wr1(wr[1]),
    .o_ack0(ack[0]), .o_ack1(ack[1]),
    .o_rdata0(rdata[0]), .o_rdata1(rdata[1]),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_size(o_mem_size), .o_mem_we(o_mem_we),
    .i_mem_data(mem_rd), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-on memory contents, shared by memory model and reference.
  function automatic logic [31:0] pat(input logic [13:0] idx);
    return ({18'd0, idx} * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // Word-organised little-endian memory: zero-extends narrow reads and
  // ignores the low address bits below the access size.
  always_comb begin
    wcur = written[o_mem_addr[15:2]] ? mem_w[o_mem_addr[15:2]] : pat(o_mem_addr[15:2]);
    wnew = wcur;
    mem_rd = wcur;
    case (o_mem_size)
      2'b00: begin
        wnew[{o_mem_addr[1:0], 3'b000} +: 8] = o_mem_data[7:0];
        mem_rd = {24'd0, wcur[{o_mem_addr[1:0], 3'b000} +: 8]};
      end
      2'b01, 2'b10: begin
        if (o_mem_addr[1]) wnew[31:16] = o_mem_data[15:0];
        else               wnew[15:0]  = o_mem_data[15:0];
        mem_rd = {16'd0, o_mem_addr[1] ? wcur[31:16] : wcur[15:0]};
      end
      default: begin
        wnew = o_mem_data;
        mem_rd = wcur;
      end
    endcase
  end

  always @(posedge clk) begin
    if (!o_mem_we) begin
      mem_w[o_mem_addr[15:2]]   <= wnew;
      written[o_mem_addr[15:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] env_word(input logic [13:0] idx);
    return written[idx] ? mem_w[idx] : pat(idx);
  endfunction

  // Byte-array reference model.
  function automatic logic [31:0] ref_read(input logic [15:0] a, input logic [1:0] sz);
    logic [15:0] h, w;
    h = {a[15:1], 1'b0};
    w = {a[15:2], 2'b00};
    case (sz)
      2'b00:        return {24'd0, ref_mem[a]};
      2'b01, 2'b10: return {16'd0, ref_mem[h | 16'd1], ref_mem[h]};
      default:      return {ref_mem[w | 16'd3], ref_mem[w | 16'd2], ref_mem[w | 16'd1], ref_mem[w]};
    endcase
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [15:0] h, w;
    h = {a[15:1], 1'b0};
    w = {a[15:2], 2'b00};
    case (sz)
      2'b00: ref_mem[a] = d[7:0];
      2'b01, 2'b10: begin
        ref_mem[h] = d[7:0];
        ref_mem[h | 16'd1] = d[15:8];
      end
      default: begin
        ref_mem[w] = d[7:0];
        ref_mem[w | 16'd1] = d[15:8];
        ref_mem[w | 16'd2] = d[23:16];
        ref_mem[w | 16'd3] = d[31:24];
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Issue one request on port p; called at #1 after a rising edge.
  task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, input bit scramble, output int ack_cyc);
    exp_t e;
    bit got;
    logic [31:0] r;
    e.wr = w;
    e.data = w ? 32'd0 : ref_read(a[15:0], sz);
    if (w) ref_write(a[15:0], sz, wd);
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    req[p] = 1'b1; wr[p] = w; addr[p] = a; size[p] = sz; wdata[p] = wd;
    if (scramble) begin
      @(posedge clk); #1;
      r = $urandom;
      addr[p] = r; wdata[p] = ~r; size[p] = r[1:0]; wr[p] = r[2];
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack[p]) got = 1'b1;
    end
    chk($sformatf("ack%0d_timeout", p), {31'd0, got}, 32'd1);
    ack_cyc = cyc;
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic rand_txn(input int p, output int ack_cyc);
    logic [31:0] a, d, r;
    a = $urandom;
    a[15] = (p == 1);
    d = $urandom;
    r = $urandom;
    txn(p, r[0], a, r[2:1], d, 1'b0, ack_cyc);
  endtask

  // Scoreboard monitor.
  initial begin
    bit prev_ack, prev_we;
    logic [31:0] last_rd [2];
    exp_t e;
    prev_ack = 0; prev_we = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ack = 0; prev_we = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        chk("ack_in_reset", {31'd0, ack[0] | ack[1]}, 32'd0);
      end else begin
        if (!o_mem_we) begin
          we_low_cnt++;
          chk("we_width", {31'd0, prev_we}, 32'd0);
        end
        prev_we = !o_mem_we;
        if (ack[0] || ack[1]) begin
          chk("ack_adjacent", {31'd0, prev_ack}, 32'd0);
          chk("ack_onehot", {31'd0, ack[0] & ack[1]}, 32'd0);
        end
        prev_ack = ack[0] || ack[1];
        for (int p = 0; p < 2; p++) begin
          if (ack[p]) begin
            if (gq.size() > 0) chk("grant_order", p, gq.pop_front());
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              chk($sformatf("unexpected_ack%0d", p), 32'd1, 32'd0);
            end else begin
              e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (e.wr) begin
                chk($sformatf("rdata%0d_on_write", p), rdata[p], last_rd[p]);
              end else begin
                chk($sformatf("rdata%0d", p), rdata[p], e.data);
                last_rd[p] = e.data;
              end
            end
          end else begin
            chk($sformatf("rdata%0d_hold", p), rdata[p], last_rd[p]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, w0;
    logic [31:0] a, hold0;
    logic [15:0] wb;
    for (int i = 0; i < 16384; i++) begin
      a = pat(14'(i));
      ref_mem[4*i]   = a[7:0];
      ref_mem[4*i+1] = a[15:8];
      ref_mem[4*i+2] = a[23:16];
      ref_mem[4*i+3] = a[31:24];
    end
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; wr[p] = 0; addr[p] = '0; wdata[p] = '0; size[p] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack[0]}, 32'd0);
    chk("rst_ack1", {31'd0, ack[1]}, 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_rdata1", rdata[1], 32'd0);
    chk("rst_we", {31'd0, o_mem_we}, 32'd1);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_data", o_mem_data, 32'd0);
    chk("rst_size", {30'd0, o_mem_size}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous first request after reset.
    gq.push_back(0); gq.push_back(1);
    fork
      begin txn(0, 1'b0, 32'h0000_1234, 2'b11, 32'd0, 1'b0, c0); end
      begin txn(1, 1'b0, 32'h0000_9876, 2'b11, 32'd0, 1'b0, c1); end
    join
    chk("tie_spacing", c1 - c0, 32'd3);

    // Continuous contention: 8 grants alternating.
    for (int i = 0; i < 4; i++) begin gq.push_back(0); gq.push_back(1); end
    fork
      begin for (int i = 0; i < 4; i++) rand_txn(0, c0); end
      begin for (int i = 0; i < 4; i++) rand_txn(1, c1); end
    join
    chk("contention_drained", gq.size(), 32'd0);

    // Single read of a word set up through port 1.
    txn(1, 1'b1, 32'h0000_0100, 2'b11, 32'hDEADBEEF, 1'b0, c1);
    w0 = we_low_cnt; c0 = cyc;
    txn(0, 1'b0, 32'h0000_0100, 2'b11, 32'd0, 1'b1, c1);
    chk("read_latency", c1 - c0, 32'd2);
    chk("read_we_cycles", we_low_cnt - w0, 32'd0);
    chk("read_value", rdata[0], 32'hDEADBEEF);

    // Byte write then word readback.
    w0 = we_low_cnt;
    txn(1, 1'b1, 32'h0000_0203, 2'b00, 32'h0000_00A5, 1'b0, c1);
    chk("write_we_cycles", we_low_cnt - w0, 32'd1);
    txn(1, 1'b0, 32'h0000_0200, 2'b11, 32'd0, 1'b0, c1);
    chk("byte_lane", {24'd0, rdata[1][31:24]}, 32'h0000_00A5);

    // Halfword read of the upper half of a word.
    txn(0, 1'b1, 32'h0000_0040, 2'b11, 32'h11223344, 1'b0, c0);
    hold0 = rdata[0];
    txn(1, 1'b0, 32'h0000_0042, 2'b01, 32'd0, 1'b0, c1);
    chk("halfword", rdata[1], 32'h0000_1122);
    chk("halfword_rdata0", rdata[0], hold0);

    // Random traffic on disjoint halves of memory.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_txn(0, c0);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_txn(1, c1);
        end
      end
    join

    // Reset during the ACCESS cycle of a write.
    @(posedge clk); #1;
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0300; size[0] = 2'b11;
    wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #2;
    chk("abort_in_access", {31'd0, o_mem_we}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, o_mem_we}, 32'd1);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_ack0", {31'd0, ack[0]}, 32'd0);
    chk("abort_rdata0", rdata[0], 32'd0);
    req[0] = 1'b0; wr[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wb = 16'h0300;
    chk("abort_mem", env_word(14'h00C0), ref_read(wb, 2'b11));
    rst_n = 1'b1;
    gq.push_back(0); gq.push_back(1);
    fork
      begin txn(0, 1'b0, 32'h0000_0300, 2'b11, 32'd0, 1'b0, c0); end
      begin txn(1, 1'b0, 32'h0000_8300, 2'b11, 32'd0, 1'b0, c1); end
    join
    chk("post_reset_tie", {31'd0, c0 < c1}, 32'd1);

    repeat (4) @(posedge clk);
    chk("exp_q0_empty", exp_q0.size(), 32'd0);
    chk("exp_q1_empty", exp_q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single byte-addressable 64K memory between the instruction-fetch unit (port 0) and the load/store unit (port 1). It accepts level-held requests, picks one winner using round-robin, latches the winning request, and drives the memory for one cycle. It then returns read data with a one-cycle acknowledge. It sits between the CPU core and the memory block and is the only driver of the memory's address, data, size and write-enable inputs.

## Interface
Parameters: none (the address width is fixed at 32 and passed through unchanged; the memory ignores the upper bits).

- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req0 / i_req1  in  1  request from port 0 / port 1; level, held until ack
- i_addr0 / i_addr1  in  32  byte address
- i_wdata0 / i_wdata1  in  32  write data (low byte or halfword for narrow sizes)
- i_size0 / i_size1  in  2  00 byte, 01/10 halfword, 11 word
- i_wr0 / i_wr1  in  1  1 = write, 0 = read (active high at the requester side)
- o_ack0 / o_ack1  out  1  one-cycle pulse: request completed
- o_rdata0 / o_rdata1  out  32  read data; valid while the matching ack is high and held until the next read on that port
- o_mem_addr  out  32  to memory i_addr
- o_mem_data  out  32  to memory i_data
- o_mem_size  out  2  to memory i_size
- o_mem_we  out  1  to memory i_we, active low
- i_mem_data  in  32  from memory o_data; combinational read
- o_busy  out  1  high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - With no request pending, stay in IDLE.
  - Otherwise select a winner and latch its addr, wdata, size and wr into internal registers plus a grant-id bit, then go to ACCESS.
- **Winner selection**
  - Only one request pending: that port wins.
  - Both pending: the port not named in the last-grant register wins.
  - The last-grant register updates to the winner on every IDLE->ACCESS transition.
- **ACCESS** (exactly one cycle)
  - Memory outputs are driven from the latched registers.
  - o_mem_we = 0 only if the latched wr = 1.
  - At the closing edge:
    - for a write, the memory commits the data;
    - for a read, i_mem_data is captured into the granted port's o_rdata register.
  - Next state is DONE.
- **DONE** (one cycle)
  - The ack of the granted port is high.
  - No arbitration takes place in this cycle; both reqs are ignored.
  - Next state is IDLE.
- **Requester rule:** after seeing ack, the requester either drops req or presents a new request at the next edge. The arbiter samples it in the following IDLE cycle.
- **Outside ACCESS:** o_mem_we = 1. o_mem_addr, o_mem_data and o_mem_size keep their latched values; they are don't-care to the memory.
- **Data widths:** the arbiter does no alignment or extension.
  - The memory zero-extends byte/halfword reads and forces address alignment.
  - o_rdata carries i_mem_data unmodified.
- **Writes:** do not modify o_rdata.
- Requester inputs that change while a request is granted and not yet acked have no effect, because the request is already latched.

## Timing
- **Reset values:**
  - state IDLE
  - last-grant = 1, so port 0 wins the first tie
  - o_ack0 = o_ack1 = 0
  - o_rdata0 = o_rdata1 = 0
  - o_mem_we = 1
  - o_mem_addr, o_mem_data and o_mem_size all 0
  - o_busy = 0
- **Latency:** req is sampled high at edge E0. ACCESS is the cycle after E0, ack is high the cycle after that, so ack appears 2 cycles after sampling.
- **Throughput:** a new grant can occur no earlier than 3 cycles after the previous one; there is one access per 3 cycles maximum.
- **Contention:** with both reqs held continuously, grants alternate 0,1,0,1… There is no starvation; the worst-case wait is 5 cycles from sampling to ack.
- **Asynchronous reset mid-operation:**
  - All outputs go to their reset values immediately.
  - o_mem_we rises at once.
  - A write in ACCESS is aborted if reset is asserted before the closing edge.
  - A pending ack is lost, so the requester must reissue.
- **Reset release:** the first arbitration happens at the first rising edge with i_rst_n high.

## Test plan
- **Single read:**
  - Setup: memory word 0x100 = 0xDEADBEEF.
  - Stimulus: port 0 reqs a size-11 read at 0x100.
  - Required: o_mem_we stays 1; o_ack0 pulses 2 cycles after sampling; o_rdata0 = 0xDEADBEEF; o_ack1 stays 0.
- **Write then read:**
  - Stimulus: port 1 writes byte 0xA5 to 0x203 (size 00), then reads word 0x200.
  - Required: o_mem_we = 0 for exactly one cycle; the readback has bits [31:24] = 0xA5 and the other bytes are unchanged.
- **Simultaneous first request after reset:**
  - Stimulus: both ports request.
  - Required: port 0 is acked first, and port 1 is acked exactly 3 cycles later.
- **Continuous contention:**
  - Stimulus: both reqs held high for 8 grants.
  - Required: ack order 0,1,0,1,0,1,0,1; no two acks in adjacent cycles.
- **Halfword read:**
  - Setup: word 0x40 = 0x11223344.
  - Stimulus: a size-01 read at 0x42 on port 1.
  - Required: o_rdata1 = 0x00001122; o_rdata0 unchanged.
- **Reset mid-write:**
  - Stimulus: assert i_rst_n = 0 during the ACCESS cycle of a write of 0xCAFEF00D to 0x300.
  - Required: o_mem_we = 1 immediately; memory at 0x300 keeps its old value; no ack is produced; o_busy = 0; after release, a port-0 request wins the tie.
